pmem_burst_responder: RTL

- Physical-memory-side responder for the 64-bit burst interface driven by the cacheline adaptor.
- Accepts one read or write request per 256-bit line and answers with exactly 4 beats of 64 bits after a configurable latency.
- Backed by an internal line-organised storage array.
- Used as the memory endpoint under the cache subsystem in simulation and in FPGA bring-up.

---
 rtl/pmem_burst_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pmem_burst_responder.sv
// Memory-side burst responder. Each read/write request moves one 256-bit line
// as four 64-bit beats after a fixed latency, backed by a line-organised array.
module pmem_burst_responder #(
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [31:0] pmem_address,
    input  logic [63:0] pmem_wdata,
    output logic [63:0] pmem_rdata,
    output logic        pmem_resp,
    output logic        err,
    output logic [15:0] rd_bursts,
    output logic [15:0] wr_bursts
);

    localparam int IW = $clog2(DEPTH_LINES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  lat_cnt, lat_cnt_nxt;
    logic [1:0]  beat, beat_nxt;
    logic        op_wr, op_wr_nxt;
    // Full line address (address[31:5]) is kept so a mid-burst change in any
    // address bit is flagged, even bits that only alias onto the same index.
    logic [26:0] line_addr, line_addr_nxt;
    logic        violation;

    logic [IW-1:0] idx, idx_nxt;
    assign idx     = line_addr[IW-1:0];
    assign idx_nxt = line_addr_nxt[IW-1:0];

    // Byte offset within a line never selects anything.
    logic unused_addr_bits;
    assign unused_addr_bits = ^pmem_address[4:0];

    // Line storage, one 64-bit word per beat.
    logic [63:0] mem [DEPTH_LINES][4];

    // Beat strobe follows the state directly so it drops the cycle after rst.
    assign pmem_resp = (state == S_BURST);

    // Next-state, latched request fields and protocol checking.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_nxt     = state;
        lat_cnt_nxt   = lat_cnt;
        beat_nxt      = beat;
        op_wr_nxt     = op_wr;
        line_addr_nxt = line_addr;
        violation     = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (pmem_read || pmem_write) begin
                    op_wr_nxt     = pmem_write;       // write wins a collision
                    line_addr_nxt = pmem_address[31:5];
                    lat_cnt_nxt   = 4'(LATENCY - 1);
                    beat_nxt      = 2'd0;
                    violation     = pmem_read && pmem_write;
                    state_nxt     = (LATENCY == 1) ? S_BURST : S_WAIT;
                end
            end
            S_WAIT: begin
                lat_cnt_nxt = lat_cnt - 4'd1;
                if (lat_cnt == 4'd1) begin
                    state_nxt = S_BURST;
                    beat_nxt  = 2'd0;
                end
            end
            S_BURST: begin
                beat_nxt = beat + 2'd1;
                if (beat == 2'd3) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Initiator must hold op and address stable until the last beat.
        if (state == S_WAIT || state == S_BURST) begin
            if ((op_wr ? !pmem_write : !pmem_read) ||
                (pmem_address[31:5] != line_addr)) begin
                violation = 1'b1;
            end
        end
    end

    // Control state, registered read beat, sticky error and burst counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before this edge.
        if (rst) begin
            state      <= S_IDLE;
            lat_cnt    <= '0;
            beat       <= '0;
            op_wr      <= 1'b0;
            line_addr  <= '0;
            pmem_rdata <= '0;
            err        <= 1'b0;
            rd_bursts  <= '0;
            wr_bursts  <= '0;
        end else begin
            state     <= state_nxt;
            lat_cnt   <= lat_cnt_nxt;
            beat      <= beat_nxt;
            op_wr     <= op_wr_nxt;
            line_addr <= line_addr_nxt;
            err       <= err | violation;

            // Load the beat that will be on the bus next cycle; zero otherwise.
            if (state_nxt == S_BURST && !op_wr_nxt) begin
                pmem_rdata <= mem[idx_nxt][beat_nxt];
            end else begin
                pmem_rdata <= '0;
            end

            if (state == S_DONE) begin
                if (op_wr) begin
                    if (wr_bursts != 16'hFFFF) wr_bursts <= wr_bursts + 16'd1;
                end else begin
                    if (rd_bursts != 16'hFFFF) rd_bursts <= rd_bursts + 16'd1;
                end
            end
        end
    end

    // Capture one write beat at the end of each resp-high cycle.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; rst only blocks the beat being
        // captured on the aborting edge so earlier beats survive.
        if (!rst && state == S_BURST && op_wr) begin
            mem[idx][beat] <= pmem_wdata;
        end
    end

endmodule
